// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU slice.
// Holds the loader state encoding and word sizing.
package cpu_pkg;
    typedef enum logic [1:0] {LD_HDR, LD_LOAD, LD_DONE} loader_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/instr_loader_byte_packer.sv
// Little-endian 8->32 byte packer with a 2-bit lane index.
// word/word_valid are presented in the same cycle the 4th byte is strobed.
module byte_packer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        strobe,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [1:0]  idx;
    logic [23:0] low;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            idx <= 2'd0;
            low <= 24'd0;
        end else if (strobe) begin
            idx <= idx + 2'd1;
            unique case (idx)
                2'd0:    low[7:0]   <= data;
                2'd1:    low[15:8]  <= data;
                2'd2:    low[23:16] <= data;
                default: ;
            endcase
        end
    end

    // Top lane comes straight from the bus so the caller can register it.
    assign word       = {data, low};
    assign word_valid = strobe && (idx == 2'd3);
endmodule

// File: rtl/instr_loader.sv
// Streams a length-prefixed image into instruction RAM.
// Holds the core in reset until the whole image has been consumed.
module instr_loader
    import cpu_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        reload,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rstn,
    output logic        load_done,
    output logic        overflow,
    output logic [31:0] word_cnt
);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [31:0] STEP    = 32'(WORD_BYTES);

    loader_state_t state;
    logic [31:0]   total;
    logic [31:0]   limit;
    logic [31:0]   seen;
    logic          accept;
    logic          clear;
    logic          word_valid;
    logic [31:0]   word;

    assign rx_ready = rstn && (state != LD_DONE);
    assign accept   = rx_valid && rx_ready;
    assign clear    = (state == LD_DONE) && reload;

    byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (clear),
        .strobe     (accept),
        .data       (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= LD_HDR;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
            cpu_rstn   <= 1'b0;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            word_cnt   <= 32'd0;
            total      <= 32'd0;
            limit      <= 32'd0;
            seen       <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                LD_HDR: begin
                    if (word_valid) begin
                        total    <= word;
                        limit    <= (word > DEPTH_W) ? DEPTH_W : word;
                        overflow <= overflow | (word > DEPTH_W);
                        seen     <= 32'd0;
                        if (word == 32'd0) begin
                            state     <= LD_DONE;
                            load_done <= 1'b1;
                        end else begin
                            state <= LD_LOAD;
                        end
                    end
                end
                LD_LOAD: begin
                    if (word_valid) begin
                        seen <= seen + 32'd1;
                        // Words past the RAM depth are drained, not written.
                        if (word_cnt < limit) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= word;
                            imem_addr  <= BASE_ADDR + word_cnt * STEP;
                            word_cnt   <= word_cnt + 32'd1;
                        end
                        if (seen + 32'd1 == total) begin
                            state     <= LD_DONE;
                            load_done <= 1'b1;
                        end
                    end
                end
                LD_DONE: begin
                    if (reload) begin
                        state     <= LD_HDR;
                        cpu_rstn  <= 1'b0;
                        load_done <= 1'b0;
                        overflow  <= 1'b0;
                        word_cnt  <= 32'd0;
                        imem_addr <= BASE_ADDR;
                    end else begin
                        cpu_rstn <= 1'b1;
                    end
                end
                default: state <= LD_HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with DEPTH=4.
// Covers normal, empty, overflow, gapped, mid-load reset and reload.
module tb_instr_loader;
    logic        clk = 1'b0;
    logic        rstn;
    logic        reload;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rstn;
    logic        load_done;
    logic        overflow;
    logic [31:0] word_cnt;

    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          acc_cnt = 0;
    int          sent = 0;
    bit          gaps = 1'b0;
    logic [31:0] mem [0:15];
    int          we0;

    instr_loader #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .reload     (reload),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rstn   (cpu_rstn),
        .load_done  (load_done),
        .overflow   (overflow),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            we_cnt = we_cnt + 1;
            mem[imem_addr[5:2]] = imem_wdata;
        end
        if (rx_valid && rx_ready)
            acc_cnt = acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        bit acc = 1'b0;
        if (gaps && $urandom_range(0, 1) == 1) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 2)) step();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
        end
        if (acc)
            sent = sent + 1;
        else
            check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit exp_we,
                             input logic [31:0] exp_addr);
        put(w[7:0]);
        put(w[15:8]);
        put(w[23:16]);
        put(w[31:24]);
        check("we_latency", {31'd0, imem_we}, {31'd0, exp_we});
        if (exp_we) begin
            check("wr_addr", imem_addr, exp_addr);
            check("wr_data", imem_wdata, w);
        end
    endtask

    task automatic do_reload();
        reload   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        step();
        reload   = 1'b0;
        rx_valid = 1'b0;
        check("rl_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
        check("rl_done", {31'd0, load_done}, 32'd0);
        check("rl_word_cnt", word_cnt, 32'd0);
        check("rl_no_consume", acc_cnt, sent);
    endtask

    task automatic finish_done(input logic [31:0] exp_cnt);
        rx_valid = 1'b0;
        check("done_flag", {31'd0, load_done}, 32'd1);
        check("done_ready", {31'd0, rx_ready}, 32'd0);
        check("done_cpu_hold", {31'd0, cpu_rstn}, 32'd0);
        step();
        check("done_cpu_rel", {31'd0, cpu_rstn}, 32'd1);
        check("done_cnt", word_cnt, exp_cnt);
        check("acc_bytes", acc_cnt, sent);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFF;
        rstn     = 1'b0;
        reload   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        step();
        step();
        check("rst_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_cpu", {31'd0, cpu_rstn}, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_cnt", word_cnt, 32'd0);
        rstn = 1'b1;
        step();
        check("hdr_ready", {31'd0, rx_ready}, 32'd1);

        // Two-word image, back-to-back bytes
        send_word(32'd2, 1'b0, 32'h0);
        send_word(32'h0000_0013, 1'b1, 32'h0);
        send_word(32'h0010_0093, 1'b1, 32'h4);
        finish_done(32'd2);
        check("s1_we_cnt", we_cnt, 32'd2);
        check("s1_mem0", mem[0], 32'h0000_0013);
        check("s1_mem1", mem[1], 32'h0010_0093);

        // Empty image
        do_reload();
        we0 = we_cnt;
        send_word(32'd0, 1'b0, 32'h0);
        check("s2_ovf", {31'd0, overflow}, 32'd0);
        finish_done(32'd0);
        check("s2_no_we", we_cnt, we0);

        // Header exceeds depth: 4 writes, 2 drained
        do_reload();
        we0 = we_cnt;
        send_word(32'd6, 1'b0, 32'h0);
        check("s3_ovf", {31'd0, overflow}, 32'd1);
        send_word(32'hA000_0001, 1'b1, 32'h0);
        send_word(32'hA000_0002, 1'b1, 32'h4);
        send_word(32'hA000_0003, 1'b1, 32'h8);
        send_word(32'hA000_0004, 1'b1, 32'hC);
        check("s3_ready_drain", {31'd0, rx_ready}, 32'd1);
        send_word(32'hA000_0005, 1'b0, 32'h0);
        send_word(32'hA000_0006, 1'b0, 32'h0);
        check("s3_addr_max", imem_addr, 32'hC);
        finish_done(32'd4);
        check("s3_we_cnt", we_cnt - we0, 32'd4);
        check("s3_mem3", mem[3], 32'hA000_0004);
        check("s3_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Same two-word image with random valid gaps
        do_reload();
        check("s4_ovf_clr", {31'd0, overflow}, 32'd0);
        we0  = we_cnt;
        gaps = 1'b1;
        send_word(32'd2, 1'b0, 32'h0);
        send_word(32'h0000_0013, 1'b1, 32'h0);
        send_word(32'h0010_0093, 1'b1, 32'h4);
        gaps = 1'b0;
        finish_done(32'd2);
        check("s4_we_cnt", we_cnt - we0, 32'd2);
        check("s4_mem0", mem[0], 32'h0000_0013);
        check("s4_mem1", mem[1], 32'h0010_0093);
        check("s4_mem2", mem[2], 32'hA000_0003);

        // Reset mid-load drops the partial word
        do_reload();
        we0 = we_cnt;
        send_word(32'd3, 1'b0, 32'h0);
        send_word(32'h5555_0001, 1'b1, 32'h0);
        put(8'h77);
        put(8'h66);
        rx_valid = 1'b0;
        rstn     = 1'b0;
        step();
        check("s5_rst_cnt", word_cnt, 32'd0);
        check("s5_rst_we", {31'd0, imem_we}, 32'd0);
        check("s5_rst_cpu", {31'd0, cpu_rstn}, 32'd0);
        check("s5_rst_addr", imem_addr, 32'h0);
        rstn = 1'b1;
        step();
        step();
        check("s5_partial_nowr", we_cnt - we0, 32'd1);
        send_word(32'd1, 1'b0, 32'h0);
        send_word(32'hDEAD_BEEF, 1'b1, 32'h0);
        finish_done(32'd1);
        check("s5_mem0", mem[0], 32'hDEAD_BEEF);
        check("s5_mem1", mem[1], 32'h0010_0093);
        check("s5_we_cnt", we_cnt - we0, 32'd2);

        // Reload then load again from base
        do_reload();
        send_word(32'd1, 1'b0, 32'h0);
        send_word(32'h1234_5678, 1'b1, 32'h0);
        finish_done(32'd1);
        check("s6_mem0", mem[0], 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
